large_array_write_ila: RTL and testbench

Write-side instruction model for the LargeArray ILA: decodes the WRITE instruction (`wen` high, `ren` low) and commits `data` into a 16-entry x 8-bit state array. It maintains the post-decode instruction-start counter used by the refinement checker, plus a per-entry written mask. It exposes a combinational peek port so the READ-side model and the verification harness observe the same array state. It sits beside the READ model in the vpipe/vmem LargeArray test and drives the array that READ consumes.

---
 rtl/large_array_write_ila_pkg.sv | 15 +
 rtl/large_array_write_ila_if.sv | 37 +++
 rtl/large_array_write_ila_counter.sv | 47 ++++
 rtl/large_array_write_ila.sv | 63 ++++++
 tb/tb_large_array_write_ila.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/large_array_write_ila_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// large_array_pkg : shared sizing for the LargeArray ILA READ/WRITE models
// Revision: 1.0
// ---------------------------------------------------------------------------
package large_array_pkg;

    localparam int ADDR_W_DFLT = 4;
    localparam int DATA_W_DFLT = 8;
    localparam int CNT_W_DFLT  = 8;
    localparam int DEPTH       = 2 ** ADDR_W_DFLT;
    localparam int CNT_MAX     = (2 ** CNT_W_DFLT) - 1;

endpackage : large_array_pkg
`default_nettype wire

// File: rtl/large_array_write_ila_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// large_array_write_ila_if : instruction inputs and array observation outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
import large_array_pkg::*;

interface large_array_write_ila_if #(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT,
    parameter int CNT_W  = CNT_W_DFLT
);
    logic                   start;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      data;
    logic                   wen;
    logic                   ren;
    logic [ADDR_W-1:0]      peek_addr;
    logic                   decode_of_write;
    logic                   valid;
    logic [DATA_W-1:0]      peek_data;
    logic [2**ADDR_W-1:0]   written_mask;
    logic [DATA_W-1:0]      last_wdata;
    logic [CNT_W-1:0]       write_cnt;

    modport master (
        output start, addr, data, wen, ren, peek_addr,
        input  decode_of_write, valid, peek_data, written_mask, last_wdata, write_cnt
    );

    modport slave (
        input  start, addr, data, wen, ren, peek_addr,
        output decode_of_write, valid, peek_data, written_mask, last_wdata, write_cnt
    );

endinterface : large_array_write_ila_if
`default_nettype wire

// File: rtl/large_array_write_ila_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// large_array_inst_counter : saturating instruction-start counter
// Revision: 1.0
// ---------------------------------------------------------------------------
import large_array_pkg::*;

module large_array_inst_counter #(
    parameter int CNT_W = CNT_W_DFLT
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start_i,
    input  wire logic             load_i,
    output logic [CNT_W-1:0]      cnt_o
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Zero means "no write seen yet" and must never start counting by itself.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            if (load_i) begin
                cnt_d = c_cnt_one;
            end else if ((cnt_q != '0) && (cnt_q != c_cnt_max)) begin
                cnt_d = cnt_q + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : large_array_inst_counter
`default_nettype wire

// File: rtl/large_array_write_ila.sv
`default_nettype none
// ---------------------------------------------------------------------------
// large_array_write_ila : WRITE instruction model of the LargeArray ILA
// Revision: 1.0
// ---------------------------------------------------------------------------
import large_array_pkg::*;

module large_array_write_ila #(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT,
    parameter int CNT_W  = CNT_W_DFLT
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    large_array_write_ila_if.slave    bus
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0]  mem_q [c_depth];
    logic [c_depth-1:0] mask_q;
    logic [DATA_W-1:0]  last_wdata_q;
    logic               w_decode;
    logic               w_valid;
    logic               w_commit;

    // READ wins a wen/ren collision, keeping the two decodes disjoint.
    assign w_decode = bus.wen & ~bus.ren;
    assign w_valid  = 1'b1;
    assign w_commit = bus.start & w_valid & w_decode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_depth; i++) begin
                mem_q[i] <= '0;
            end
            mask_q       <= '0;
            last_wdata_q <= '0;
        end else if (w_commit) begin
            mem_q[bus.addr]  <= bus.data;
            mask_q[bus.addr] <= 1'b1;
            last_wdata_q     <= bus.data;
        end
    end

    large_array_inst_counter #(
        .CNT_W (CNT_W)
    ) u_inst_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (bus.start),
        .load_i  (w_commit),
        .cnt_o   (bus.write_cnt)
    );

    assign bus.decode_of_write = w_decode;
    assign bus.valid           = w_valid;
    assign bus.peek_data       = mem_q[bus.peek_addr];
    assign bus.written_mask    = mask_q;
    assign bus.last_wdata      = last_wdata_q;

endmodule : large_array_write_ila
`default_nettype wire

// File: tb/tb_large_array_write_ila.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_large_array_write_ila : directed self-checking bench for the WRITE model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_large_array_write_ila;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    large_array_write_ila_if bus ();

    large_array_write_ila u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string tag);
        bus.peek_addr = a;
        #1;
        check(tag, 32'(bus.peek_data), 32'(exp));
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_cnt;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.addr      = '0;
        bus.data      = '0;
        bus.wen       = 1'b0;
        bus.ren       = 1'b0;
        bus.peek_addr = '0;

        // Asynchronous reset before any clock edge has occurred.
        #2 rst_n = 1'b0;
        #1;
        check("rst_mask", 32'(bus.written_mask), 32'h0000);
        check("rst_cnt", 32'(bus.write_cnt), 32'd0);
        check("rst_last", 32'(bus.last_wdata), 32'h00);
        check("valid", 32'(bus.valid), 32'd1);
        for (int i = 0; i < 16; i++) begin
            peek(4'(i), 8'h00, "rst_peek");
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Basic write
        bus.start = 1'b1; bus.wen = 1'b1; bus.ren = 1'b0;
        bus.addr = 4'd5; bus.data = 8'hA7;
        #1 check("dec_write", 32'(bus.decode_of_write), 32'd1);
        step();
        bus.wen = 1'b0;
        peek(4'd5, 8'hA7, "wr_peek5");
        check("wr_mask", 32'(bus.written_mask), 32'h0020);
        check("wr_last", 32'(bus.last_wdata), 32'hA7);
        check("wr_cnt", 32'(bus.write_cnt), 32'd1);

        // Collision: read wins
        bus.wen = 1'b1; bus.ren = 1'b1; bus.addr = 4'd3; bus.data = 8'h11;
        #1 check("coll_dec", 32'(bus.decode_of_write), 32'd0);
        step();
        bus.wen = 1'b0; bus.ren = 1'b0;
        peek(4'd3, 8'h00, "coll_peek3");
        check("coll_mask", 32'(bus.written_mask), 32'h0020);
        check("coll_last", 32'(bus.last_wdata), 32'hA7);
        check("coll_cnt", 32'(bus.write_cnt), 32'd2);

        // start low freezes everything
        bus.start = 1'b0; bus.wen = 1'b1; bus.addr = 4'd3; bus.data = 8'h22;
        #1 check("gate_dec", 32'(bus.decode_of_write), 32'd1);
        step();
        bus.wen = 1'b0;
        peek(4'd3, 8'h00, "gate_peek3");
        check("gate_mask", 32'(bus.written_mask), 32'h0020);
        check("gate_cnt", 32'(bus.write_cnt), 32'd2);
        check("gate_last", 32'(bus.last_wdata), 32'hA7);

        // Counter saturation
        bus.start = 1'b1; bus.wen = 1'b1; bus.addr = 4'd2; bus.data = 8'h5C;
        step();
        bus.wen = 1'b0;
        check("sat_cnt0", 32'(bus.write_cnt), 32'd1);
        check("sat_mask", 32'(bus.written_mask), 32'h0024);
        for (int k = 1; k <= 300; k++) begin
            step();
            exp_cnt = (k >= 254) ? 8'd255 : 8'(k + 1);
            check("sat_cnt", 32'(bus.write_cnt), 32'(exp_cnt));
        end
        bus.wen = 1'b1; bus.addr = 4'd2; bus.data = 8'h3D;
        step();
        bus.wen = 1'b0;
        check("reload_cnt", 32'(bus.write_cnt), 32'd1);
        check("reload_last", 32'(bus.last_wdata), 32'h3D);
        peek(4'd2, 8'h3D, "reload_peek2");

        // Full sweep then overwrite addr 7
        for (int i = 0; i < 16; i++) begin
            bus.wen = 1'b1; bus.addr = 4'(i); bus.data = 8'(8'h10 + i);
            step();
        end
        bus.addr = 4'd7; bus.data = 8'hFF;
        step();
        bus.wen = 1'b0; bus.start = 1'b0;
        check("sweep_mask", 32'(bus.written_mask), 32'hFFFF);
        check("sweep_last", 32'(bus.last_wdata), 32'hFF);
        check("sweep_cnt", 32'(bus.write_cnt), 32'd1);
        for (int i = 0; i < 16; i++) begin
            peek(4'(i), (i == 7) ? 8'hFF : 8'(8'h10 + i), "sweep_peek");
        end

        // Reset asserted during a commit cycle
        bus.start = 1'b1; bus.wen = 1'b1; bus.addr = 4'd9; bus.data = 8'h99;
        #2 rst_n = 1'b0;
        step();
        peek(4'd9, 8'h00, "mid_rst_peek9");
        check("mid_rst_cnt", 32'(bus.write_cnt), 32'd0);
        check("mid_rst_mask", 32'(bus.written_mask), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1; bus.wen = 1'b0;
        step();
        peek(4'd9, 8'h00, "post_rst_peek9");
        check("post_rst_cnt", 32'(bus.write_cnt), 32'd0);

        // First commit after reset is honoured
        bus.wen = 1'b1; bus.addr = 4'd4; bus.data = 8'h44;
        step();
        bus.wen = 1'b0;
        peek(4'd4, 8'h44, "post_rst_peek4");
        check("post_rst_mask", 32'(bus.written_mask), 32'h0010);
        check("post_rst_cnt1", 32'(bus.write_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_large_array_write_ila
`default_nettype wire
